video_timing_decoder: RTL and testbench
=======================================

# video_timing_decoder

Receive-side timing decoder for the HDMI video stream. It samples the DE/HS/VS strobes that drive the HDMI transmitter and recovers per-pixel coordinates for the overlay and font engines. It also measures the active and total frame geometry, and declares lock once the format is stable. It replaces ad-hoc x/y counters clocked on sync edges with a single HDMI_TX_CLK-synchronous block.

## Interface
Parameters:
- X_W, 12: width of horizontal counters and measurements
- Y_W, 12: width of vertical counters and measurements
- LOCK_FRAMES, 4: consecutive matching frames required to assert locked (1..15)

Ports:
- HDMI_TX_CLK  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- de_in  in  1  data enable, active-high
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- pix_x  out  X_W  column of current active pixel, 0-based
- pix_y  out  Y_W  row of current active pixel, 0-based
- pix_valid  out  1  pix_x/pix_y qualify an active pixel
- sof  out  1  one-cycle pulse on pixel (0,0) of each frame
- h_active, h_total  out  X_W  last measured DE-high clocks per line / clocks per line
- v_active, v_total  out  Y_W  last measured DE lines per frame / lines per frame
- hs_pol, vs_pol  out  1  sync active level (1 = active-high)
- locked  out  1  format stable
- fmt_change  out  1  one-cycle pulse when lock is lost
- frame_cnt  out  16  frames seen since reset, wraps

## Operation
- One input register stage samples de_in, hs_in and vs_in. Edge detection compares this stage against a second delayed copy.
- Leading edge = transition into the active level given by hs_pol/vs_pol.
- pix_x: 0 on the DE rising edge, +1 per DE-high clock. pix_y: 0 on the first DE line after a VS leading edge, +1 at each subsequent DE rising edge.
- h_total: clocks between consecutive HS leading edges, captured at each leading edge.
- h_active: DE-high clocks in a line, captured on the DE falling edge.
- v_total: HS leading edges between consecutive VS leading edges, captured on the VS leading edge.
- v_active: number of lines containing DE, captured on the VS leading edge.
- All measurement counters saturate at all-ones. A saturated or zero value marks the frame invalid.
- Lock FSM, evaluated at each VS leading edge:
  - UNLOCKED: store the measurement set as baseline and go to MEASURE.
  - MEASURE: if the set is valid and equals the baseline, match_cnt+1; otherwise replace the baseline and clear match_cnt. When match_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED: any mismatch or invalid set → fmt_change pulse, locked=0, new baseline, back to MEASURE.
- frame_cnt increments on every VS leading edge.
- Simultaneous HS and VS leading edges: the VS update is applied first, and the line counts as line 0 of the new frame.
- DE asserted during vertical blanking: counted normally. pix_y continues incrementing; it is not reset until the next VS leading edge.

## Timing
- Reset values: every output is 0, except hs_pol=1 and vs_pol=1. FSM resets to UNLOCKED, match_cnt to 0.
- pix_x, pix_y, pix_valid and sof lag de_in by exactly 2 clocks (input register + output register).
- Measurement outputs and locked/fmt_change update 2 clocks after the sampled edge that captures them.
- Reset asserted mid-frame clears everything immediately. Lock requires a fresh baseline plus LOCK_FRAMES matching frames.
- fmt_change is high for exactly one clock per loss of lock and never occurs in UNLOCKED or MEASURE.

## Configuration
- VTD_POLARITY_DETECT_EN defined:
  - Per sync signal, count high and low clocks between rising edges.
  - Polarity = 1 if the high count is less than the low count; updated once per period.
  - A polarity change while LOCKED is treated as a mismatch.
- Undefined: hs_pol and vs_pol are tied to 1, syncs are treated as active-high, and the counting logic is removed.

## Test plan
- 50×14 total, 40×10 active, active-high syncs → after baseline plus 4 matching frames, locked=1, h_total=50, h_active=40, v_total=14, v_active=10.
- Same stream → first active pixel gives pix_x=0, pix_y=0, sof=1 two clocks after de_in. Last active pixel gives pix_x=39, pix_y=9, pix_valid=1. pix_valid=0 during blanking.
- While locked, change h_active to 41 → one fmt_change pulse, locked=0. locked returns after 4 more matching frames, with h_active=41.
- Assert reset_n low for 3 clocks mid-line while locked → all outputs return to reset values. Relock takes baseline plus 4 frames; frame_cnt restarts at 0.
- With VTD_POLARITY_DETECT_EN, active-low syncs → hs_pol=0, vs_pol=0, and measurements identical to the active-high case.
- Hold hs_in inactive for more than 4095 clocks → h_total=4095 (saturated), locked stays 0 and no fmt_change pulse.

Source files
------------

// File: rtl/video_timing_decoder.sv
// video_timing_decoder
// Recovers per-pixel coordinates from the DE/HS/VS strobes feeding the HDMI
// transmitter, measures active/total frame geometry and reports lock once the
// measured format has been stable for LOCK_FRAMES consecutive frames.
// Optional feature macro: VTD_POLARITY_DETECT_EN (automatic HS/VS polarity
// detection). Without it both syncs are treated as active-high.
module video_timing_decoder #(
  parameter int X_W         = 12,
  parameter int Y_W         = 12,
  parameter int LOCK_FRAMES = 4
) (
  input  logic           HDMI_TX_CLK,
  input  logic           reset_n,
  input  logic           de_in,
  input  logic           hs_in,
  input  logic           vs_in,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_valid,
  output logic           sof,
  output logic [X_W-1:0] h_active,
  output logic [X_W-1:0] h_total,
  output logic [Y_W-1:0] v_active,
  output logic [Y_W-1:0] v_total,
  output logic           hs_pol,
  output logic           vs_pol,
  output logic           locked,
  output logic           fmt_change,
  output logic [15:0]    frame_cnt
);

  localparam logic [X_W-1:0] X_ZERO = {X_W{1'b0}};
  localparam logic [X_W-1:0] X_ONES = {X_W{1'b1}};
  localparam logic [X_W-1:0] X_ONE  = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ZERO = {Y_W{1'b0}};
  localparam logic [Y_W-1:0] Y_ONES = {Y_W{1'b1}};
  localparam logic [Y_W-1:0] Y_ONE  = {{(Y_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);
  localparam int             SET_W  = 2 + 2*X_W + 2*Y_W;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] v);
    if (v == X_ONES) return v;
    else             return v + X_ONE;
  endfunction

  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] v);
    if (v == Y_ONES) return v;
    else             return v + Y_ONE;
  endfunction

  // A measurement set is usable only if no field is zero or saturated.
  function automatic logic set_valid(input logic [X_W-1:0] ht, input logic [X_W-1:0] ha,
                                     input logic [Y_W-1:0] vt, input logic [Y_W-1:0] va);
    return (ht != X_ZERO) && (ht != X_ONES) && (ha != X_ZERO) && (ha != X_ONES) &&
           (vt != Y_ZERO) && (vt != Y_ONES) && (va != Y_ZERO) && (va != Y_ONES);
  endfunction

  logic de_r1, hs_r1, vs_r1, de_r2, hs_r2, vs_r2;
  logic de_rise_s, de_fall_s, hs_lead_s, vs_lead_s, y_start_s;
  logic y_pend_r;
  logic [X_W-1:0] h_cnt_r, de_cnt_r;
  logic [Y_W-1:0] v_cnt_r, va_cnt_r;
  lock_state_t state_r, state_nxt_s;
  logic [3:0] match_r, match_nxt_s;
  logic [SET_W-1:0] set_s, base_r;
  logic set_ok_s, base_ld_s, locked_nxt_s, fmt_nxt_s;

  // Input sampling stage plus one delayed copy for edge detection.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      {de_r1, hs_r1, vs_r1} <= 3'b000;
      {de_r2, hs_r2, vs_r2} <= 3'b000;
    end else begin
      {de_r1, hs_r1, vs_r1} <= {de_in, hs_in, vs_in};
      {de_r2, hs_r2, vs_r2} <= {de_r1, hs_r1, vs_r1};
    end
  end

  // Leading edge = entry into the active level given by the polarity flag.
  assign de_rise_s = de_r1 & ~de_r2;
  assign de_fall_s = ~de_r1 & de_r2;
  assign hs_lead_s = (hs_r1 ~^ hs_pol) & ~(hs_r2 ~^ hs_pol);
  assign vs_lead_s = (vs_r1 ~^ vs_pol) & ~(vs_r2 ~^ vs_pol);
  assign y_start_s = vs_lead_s | y_pend_r;

  // Pixel coordinate outputs; the first DE line after a VS leading edge is row 0.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      pix_x     <= X_ZERO;
      pix_y     <= Y_ZERO;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      y_pend_r  <= 1'b0;
    end else begin
      pix_valid <= de_r1;
      sof       <= de_rise_s & y_start_s;
      if (de_rise_s) begin
        pix_x    <= X_ZERO;
        pix_y    <= y_start_s ? Y_ZERO : (pix_y + Y_ONE);
        y_pend_r <= 1'b0;
      end else begin
        if (de_r1) pix_x <= pix_x + X_ONE;
        y_pend_r <= y_start_s;
      end
    end
  end

  // Geometry counters and captured measurements; a VS edge coinciding with an
  // HS edge puts that line into the new frame.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r   <= X_ZERO;
      de_cnt_r  <= X_ZERO;
      v_cnt_r   <= Y_ZERO;
      va_cnt_r  <= Y_ZERO;
      h_total   <= X_ZERO;
      h_active  <= X_ZERO;
      v_total   <= Y_ZERO;
      v_active  <= Y_ZERO;
      frame_cnt <= 16'd0;
    end else begin
      if (hs_lead_s) begin
        h_total <= h_cnt_r;
        h_cnt_r <= X_ONE;
      end else begin
        h_cnt_r <= sat_x(h_cnt_r);
      end
      if (de_rise_s)  de_cnt_r <= X_ONE;
      else if (de_r1) de_cnt_r <= sat_x(de_cnt_r);
      if (de_fall_s)  h_active <= de_cnt_r;
      if (vs_lead_s) begin
        v_total   <= v_cnt_r;
        v_active  <= va_cnt_r;
        v_cnt_r   <= hs_lead_s ? Y_ONE : Y_ZERO;
        va_cnt_r  <= de_rise_s ? Y_ONE : Y_ZERO;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        if (hs_lead_s) v_cnt_r  <= sat_y(v_cnt_r);
        if (de_rise_s) va_cnt_r <= sat_y(va_cnt_r);
      end
    end
  end

`ifdef VTD_POLARITY_DETECT_EN
  localparam int P_W = X_W + Y_W;
  localparam logic [P_W-1:0] P_ONES = {P_W{1'b1}};
  localparam logic [P_W-1:0] P_ONE  = {{(P_W-1){1'b0}}, 1'b1};
  localparam logic [P_W-1:0] P_ZERO = {P_W{1'b0}};

  function automatic logic [P_W-1:0] sat_p(input logic [P_W-1:0] v);
    if (v == P_ONES) return v;
    else             return v + P_ONE;
  endfunction

  logic [P_W-1:0] hs_hi_r, hs_lo_r, vs_hi_r, vs_lo_r;

  // Per-period high/low clock counts; the shorter level is the active one.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hs_pol  <= 1'b1;
      vs_pol  <= 1'b1;
      hs_hi_r <= P_ZERO;
      hs_lo_r <= P_ZERO;
      vs_hi_r <= P_ZERO;
      vs_lo_r <= P_ZERO;
    end else begin
      if (hs_r1 & ~hs_r2) begin
        hs_pol  <= (hs_hi_r < hs_lo_r);
        hs_hi_r <= P_ONE;
        hs_lo_r <= P_ZERO;
      end else if (hs_r1) hs_hi_r <= sat_p(hs_hi_r);
      else                hs_lo_r <= sat_p(hs_lo_r);
      if (vs_r1 & ~vs_r2) begin
        vs_pol  <= (vs_hi_r < vs_lo_r);
        vs_hi_r <= P_ONE;
        vs_lo_r <= P_ZERO;
      end else if (vs_r1) vs_hi_r <= sat_p(vs_hi_r);
      else                vs_lo_r <= sat_p(vs_lo_r);
    end
  end
`else
  // Syncs are fixed active-high in this build.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hs_pol <= 1'b1;
      vs_pol <= 1'b1;
    end else begin
      hs_pol <= 1'b1;
      vs_pol <= 1'b1;
    end
  end
`endif

  // Polarity is part of the compared set so a polarity flip breaks lock.
  assign set_s    = {hs_pol, vs_pol, h_total, h_active, v_cnt_r, va_cnt_r};
  assign set_ok_s = set_valid(h_total, h_active, v_cnt_r, va_cnt_r) && (set_s == base_r);

  // Lock state register, baseline and registered status outputs.
  always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_UNLOCKED;
      match_r    <= 4'd0;
      base_r     <= {SET_W{1'b0}};
      locked     <= 1'b0;
      fmt_change <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      match_r    <= match_nxt_s;
      if (base_ld_s) base_r <= set_s;
      locked     <= locked_nxt_s;
      fmt_change <= fmt_nxt_s;
    end
  end

  // Lock decision, evaluated once per VS leading edge.
  always_comb begin
    state_nxt_s  = state_r;
    match_nxt_s  = match_r;
    base_ld_s    = 1'b0;
    locked_nxt_s = locked;
    fmt_nxt_s    = 1'b0;
    if (vs_lead_s) begin
      case (state_r)
        ST_UNLOCKED: begin
          base_ld_s    = 1'b1;
          match_nxt_s  = 4'd0;
          locked_nxt_s = 1'b0;
          state_nxt_s  = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (set_ok_s) begin
            match_nxt_s = match_r + 4'd1;
            if ((match_r + 4'd1) == LOCK_N) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
            end else begin
              state_nxt_s  = ST_MEASURE;
            end
          end else begin
            base_ld_s   = 1'b1;
            match_nxt_s = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (set_ok_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            fmt_nxt_s    = 1'b1;
            locked_nxt_s = 1'b0;
            base_ld_s    = 1'b1;
            match_nxt_s  = 4'd0;
            state_nxt_s  = ST_MEASURE;
          end
        end
        default: begin
          state_nxt_s  = ST_UNLOCKED;
          match_nxt_s  = 4'd0;
          locked_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

endmodule

// File: tb/tb_video_timing_decoder.sv
// Scoreboard bench for video_timing_decoder: the stimulus side pushes the
// expected pixel coordinates (with arrival cycle) and expected fmt_change
// pulses; a negedge monitor pops and compares whatever the DUT presents.
// Test frame: 50x14 total, DE columns 6..6+dw-1 on lines 3..12, HS on
// columns 0..3, VS on lines 0..1.
module tb_video_timing_decoder;
  localparam int X_W = 12;
  localparam int Y_W = 12;

  logic HDMI_TX_CLK = 1'b0;
  logic reset_n = 1'b0;
  logic de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [X_W-1:0] pix_x, h_active, h_total;
  logic [Y_W-1:0] pix_y, v_active, v_total;
  logic pix_valid, sof, hs_pol, vs_pol, locked, fmt_change;
  logic [15:0] frame_cnt;

  typedef struct { int x; int y; logic sof; int t; } pix_exp_t;
  pix_exp_t exp_q[$];
  int fmt_q[$];
  pix_exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  video_timing_decoder #(.X_W(X_W), .Y_W(Y_W), .LOCK_FRAMES(4)) dut (
    .HDMI_TX_CLK(HDMI_TX_CLK), .reset_n(reset_n),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .sof(sof),
    .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked), .fmt_change(fmt_change),
    .frame_cnt(frame_cnt)
  );

  always #5 HDMI_TX_CLK = ~HDMI_TX_CLK;

  // Cycle counter used to check the fixed pixel latency.
  always @(posedge HDMI_TX_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock of stimulus; active pixels appear two clocks later.
  task automatic tick(input logic d, input logic h, input logic v, input int x, input int y);
    pix_exp_t e;
    de_in = d; hs_in = h; vs_in = v;
    if (d) begin
      e.x = x; e.y = y; e.sof = (x == 0 && y == 0); e.t = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge HDMI_TX_CLK); #1;
  endtask

  // One frame; stops early when (stop_line, stop_col) is reached.
  task automatic run_frame(input int dw, input logic inv, input int stop_line, input int stop_col);
    for (int ln = 0; ln < 14; ln++) begin
      for (int c = 0; c < 50; c++) begin
        if (ln == stop_line && c == stop_col) return;
        tick((ln >= 3 && ln <= 12 && c >= 6 && c < 6 + dw),
             (c < 4) ^ inv, (ln < 2) ^ inv, c - 6, ln - 3);
      end
    end
  endtask

  task automatic run_frames(input int n, input int dw, input logic inv);
    for (int i = 0; i < n; i++) run_frame(dw, inv, -1, -1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    repeat (3) begin @(posedge HDMI_TX_CLK); #1; end
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_pix_x", pix_x, 0);         check("rst_pix_y", pix_y, 0);
    check("rst_pix_valid", pix_valid, 0); check("rst_sof", sof, 0);
    check("rst_h_active", h_active, 0);   check("rst_h_total", h_total, 0);
    check("rst_v_active", v_active, 0);   check("rst_v_total", v_total, 0);
    check("rst_hs_pol", hs_pol, 1);       check("rst_vs_pol", vs_pol, 1);
    check("rst_locked", locked, 0);       check("rst_fmt_change", fmt_change, 0);
    check("rst_frame_cnt", frame_cnt, 0);
  endtask

  task automatic check_geometry(input string tag, input int ha);
    check({tag, "_h_total"}, h_total, 50);
    check({tag, "_h_active"}, h_active, ha);
    check({tag, "_v_total"}, v_total, 14);
    check({tag, "_v_active"}, v_active, 10);
  endtask

  // Monitor: compare every presented pixel and every fmt_change pulse.
  always @(negedge HDMI_TX_CLK) begin
    if (reset_n) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected: pix_valid=1 x=%0d y=%0d, required no active pixel", pix_x, pix_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_x", pix_x, mon_e.x);
          check("pix_y", pix_y, mon_e.y);
          check("pix_sof", sof, mon_e.sof);
          check("pix_latency_cycle", cyc, mon_e.t);
        end
      end else if (sof) begin
        checks++; errors++;
        $display("FAIL sof_without_pixel: sof=1 pix_valid=0, required sof=0");
      end
      if (fmt_change) begin
        checks++;
        if (fmt_q.size() == 0) begin
          errors++;
          $display("FAIL fmt_change_unexpected: fmt_change=1, required 0 (t=%0t)", $time);
        end else begin
          void'(fmt_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset state
    apply_reset();
    check_reset_values();
    reset_n = 1'b1;

    // Baseline frame plus four matches: lock at the sixth VS edge
    run_frames(5, 40, 1'b0);
    check("lock_pending_f5", locked, 0);
    check("frame_cnt_f5", frame_cnt, 5);
    run_frames(1, 40, 1'b0);
    check("locked_f6", locked, 1);
    check("frame_cnt_f6", frame_cnt, 6);
    check_geometry("lock40", 40);
    check("hs_pol_high", hs_pol, 1);
    check("vs_pol_high", vs_pol, 1);

    // Widen DE to 41 while locked: one fmt_change, relock after 4 matches
    fmt_q.push_back(1);
    run_frames(1, 41, 1'b0);
    run_frames(1, 41, 1'b0);
    check("unlocked_after_change", locked, 0);
    check("h_active_41", h_active, 41);
    run_frames(3, 41, 1'b0);
    check("lock_pending_41", locked, 0);
    run_frames(1, 41, 1'b0);
    check("relocked_41", locked, 1);
    check_geometry("lock41", 41);

    // Mid-line reset while locked
    run_frame(41, 1'b0, 5, 20);
    apply_reset();
    check_reset_values();
    reset_n = 1'b1;
    run_frames(5, 41, 1'b0);
    check("post_rst_lock_pending", locked, 0);
    check("post_rst_frame_cnt5", frame_cnt, 5);
    run_frames(1, 41, 1'b0);
    check("post_rst_locked", locked, 1);
    check("post_rst_frame_cnt6", frame_cnt, 6);

    // HS held inactive past counter range: saturated h_total, no lock
    apply_reset();
    reset_n = 1'b1;
    repeat (4200) tick(1'b0, 1'b0, 1'b0, 0, 0);
    run_frame(40, 1'b0, 0, 10);
    check("h_total_saturated", h_total, 4095);
    check("sat_locked", locked, 0);
    run_frames(2, 40, 1'b0);
    check("sat_still_unlocked", locked, 0);

`ifdef VTD_POLARITY_DETECT_EN
    // Active-low syncs: polarity detected, same geometry and lock
    apply_reset();
    reset_n = 1'b1;
    run_frames(10, 40, 1'b1);
    check("hs_pol_low", hs_pol, 0);
    check("vs_pol_low", vs_pol, 0);
    check("locked_low_pol", locked, 1);
    check_geometry("lowpol", 40);
`endif

    repeat (4) begin @(posedge HDMI_TX_CLK); #1; end
    check("pix_queue_drained", exp_q.size(), 0);
    check("fmt_pulse_pending", fmt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
